// File: rtl/seven_segment_scanner.sv
`timescale 1ns/1ps
// seven_segment_scanner: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. A double-buffered value is scanned one digit per
// slot through a single shared decoder, and each slot ends with a blanking
// interval so the previous digit cannot ghost onto the next anode.

// Hex nibble to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
module seven_segment_decoder (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Pure lookup of the glyph for each hex value.
    always_comb begin
        seg_o = 7'h7F;
        case (hex_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
            default: seg_o = 7'h7F;
        endcase
    end

endmodule

module seven_segment_scanner #(
    parameter int REFRESH_CYCLES = 100000,
    parameter int BLANK_CYCLES   = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [7:0]  segments,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int ON_CYCLES = REFRESH_CYCLES - BLANK_CYCLES;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    typedef enum logic {
        PHASE_ON,
        PHASE_BLANK
    } phase_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_q, digit_d;
    logic             pending_q, pending_d;
    logic [19:0]      shadow_q, shadow_d;
    logic [19:0]      active_q, active_d;
    logic             wrap_q, wrap_d;
    logic [7:0]       segments_q, segments_d;
    logic [3:0]       an_q, an_d;
    logic             frame_done_q, frame_done_d;

    phase_e     phase;
    logic       slot_end;
    logic       boundary;
    logic       show;
    logic [3:0] cur_nibble;
    logic       cur_dp;
    logic [6:0] dec_seg;
    logic [15:0] active_data;
    logic [3:0]  active_dp;

    assign active_data = active_q[15:0];
    assign active_dp   = active_q[19:16];
    assign cur_nibble  = active_data[{digit_q, 2'b00} +: 4];
    assign cur_dp      = active_dp[digit_q];

    seven_segment_decoder u_decoder (
        .hex_i (cur_nibble),
        .seg_o (dec_seg)
    );

    // Slot phase is a pure function of the slot counter: lit first, dark at the end.
    always_comb begin
        phase = PHASE_BLANK;
        if (32'(cnt_q) < 32'(ON_CYCLES)) begin
            phase = PHASE_ON;
        end
    end

    // Next-state for counters, buffers and the registered display outputs.
    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        boundary  = slot_end && (digit_q == 2'd3);
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
        digit_d   = slot_end ? digit_q + 2'd1 : digit_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (load) begin
            shadow_d  = {dp_in, data_in};
            pending_d = 1'b1;
        end
        show       = (phase == PHASE_ON) && digit_en[digit_q];
        an_d       = show ? ~(4'b0001 << digit_q) : 4'hF;
        segments_d = show ? {~cur_dp, dec_seg} : 8'hFF;
        wrap_d       = boundary;
        frame_done_d = wrap_q;
    end

    // State register with synchronous reset to a blank display showing 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            digit_q      <= 2'd0;
            pending_q    <= 1'b0;
            shadow_q     <= 20'h0;
            active_q     <= 20'h0;
            wrap_q       <= 1'b0;
            segments_q   <= 8'hFF;
            an_q         <= 4'hF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            wrap_q       <= wrap_d;
            segments_q   <= segments_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign segments   = segments_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
`timescale 1ns/1ps
// Self-checking bench for seven_segment_scanner with an 8-cycle slot and
// 2 blanking cycles. A timeline model predicts every output; directed
// literal checks pin the model at the interesting points.
module tb_seven_segment_scanner;

    localparam int RC = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        load;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [7:0]  segments;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    int unsigned modelT;
    logic [19:0] mShadow;
    logic [19:0] mActive;
    logic        mPending;
    logic [3:0]  expAn;
    logic [7:0]  expSeg;
    logic        expFd;
    logic        compareOn = 1'b0;
    logic        watchEnables = 1'b0;
    logic        watchGhost = 1'b0;
    int          enableViolations = 0;
    int          ghostHits = 0;

    seven_segment_scanner #(
        .REFRESH_CYCLES (RC),
        .BLANK_CYCLES   (BC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .load       (load),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .segments   (segments),
        .an         (an),
        .frame_done (frame_done)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    function automatic logic [6:0] hexToSeg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Timeline model: modelT is cycles since reset; slot and digit follow by division.
    task automatic modelStep();
        int pos;
        int dig;
        logic lit;
        if (reset) begin
            expAn = 4'hF; expSeg = 8'hFF; expFd = 1'b0;
            modelT = 0; mShadow = 20'h0; mActive = 20'h0; mPending = 1'b0;
        end else begin
            pos = int'(modelT % RC);
            dig = int'((modelT / RC) % 4);
            lit = (pos < RC - BC) && digit_en[dig];
            expAn  = lit ? ~(4'b0001 << dig) : 4'hF;
            expSeg = lit ? {~mActive[16 + dig], hexToSeg(mActive[dig*4 +: 4])} : 8'hFF;
            expFd  = (modelT > 0) && (modelT % (4*RC) == 0);
            if ((modelT % (4*RC) == 4*RC - 1) && mPending) begin
                mActive = mShadow;
                mPending = 1'b0;
            end
            if (load) begin
                mShadow = {dp_in, data_in};
                mPending = 1'b1;
            end
            modelT = modelT + 1;
        end
    endtask

    // Compare DUT against the model on every falling edge once reset has been seen.
    always @(negedge clk) begin
        if (compareOn) begin
            checks = checks + 1;
            if (an !== expAn || segments !== expSeg || frame_done !== expFd) begin
                errors = errors + 1;
                $display("[TB] FAIL model t=%0d got an=%b seg=%h fd=%b expected an=%b seg=%h fd=%b",
                         modelT, an, segments, frame_done, expAn, expSeg, expFd);
            end
            if (watchEnables && (an[1] == 1'b0 || an[3] == 1'b0))
                enableViolations = enableViolations + 1;
            if (watchGhost && an != 4'hF && segments[6:0] == 7'h00)
                ghostHits = ghostHits + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        modelStep();
        compareOn = 1'b1;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic r, input logic ld, input logic [15:0] d,
                                 input logic [3:0] dp, input logic [3:0] en);
        reset = r; load = ld; data_in = d; dp_in = dp; digit_en = en;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] a,
                               input logic [7:0] s, input logic fd);
        checks = checks + 1;
        if (an !== a || segments !== s || frame_done !== fd) begin
            errors = errors + 1;
            $display("[TB] FAIL %s got an=%b seg=%h fd=%b required an=%b seg=%h fd=%b",
                     name, an, segments, frame_done, a, s, fd);
        end
    endtask

    task automatic waitState(input int unsigned target);
        int n = 0;
        while (modelT != target && n < 2000) begin
            tick();
            n++;
        end
        if (modelT != target) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL wait_timeout got t=%0d required t=%0d", modelT, target);
        end
    endtask

    task automatic checkAt(input string name, input int unsigned s, input logic [3:0] a,
                           input logic [7:0] sg, input logic fd);
        waitState(s + 1);
        checkOutput(name, a, sg, fd);
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("reset_hold", 4'hF, 8'hFF, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, 4'hF);
        tick();
        checkOutput("first_edge", 4'hE, 8'hC0, 1'b0);

        applyStimulus(1'b0, 1'b1, 16'h1234, 4'h0, 4'hF);
        tick();
        load = 1'b0;
        checkAt("pre_frame_done", 31, 4'hF, 8'hFF, 1'b0);
        checkAt("f1_d0", 32, 4'hE, 8'h99, 1'b1);
        checkAt("f1_d0_last_on", 37, 4'hE, 8'h99, 1'b0);
        checkAt("f1_d0_blank", 38, 4'hF, 8'hFF, 1'b0);
        checkAt("f1_d1", 40, 4'hD, 8'hB0, 1'b0);

        applyStimulus(1'b0, 1'b1, 16'hABCD, 4'h0, 4'hF);
        tick();
        load = 1'b0;
        checkAt("tear_d2", 48, 4'hB, 8'hA4, 1'b0);
        checkAt("tear_d3", 56, 4'h7, 8'hF9, 1'b0);
        checkAt("f2_d0", 64, 4'hE, 8'hA1, 1'b1);
        checkAt("f2_d1", 72, 4'hD, 8'hC6, 1'b0);
        checkAt("f2_d2", 80, 4'hB, 8'h83, 1'b0);
        checkAt("f2_d3", 88, 4'h7, 8'h88, 1'b0);

        applyStimulus(1'b0, 1'b1, 16'h0000, 4'b0001, 4'b0101);
        tick();
        load = 1'b0;
        watchEnables = 1'b1;
        checkAt("en_d0_dp", 96, 4'hE, 8'h40, 1'b1);
        checkAt("en_d1_off", 104, 4'hF, 8'hFF, 1'b0);
        checkAt("en_d2", 112, 4'hB, 8'hC0, 1'b0);
        checkAt("en_d3_off", 120, 4'hF, 8'hFF, 1'b0);
        watchEnables = 1'b0;
        checks = checks + 1;
        if (enableViolations != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL enable_mask got %0d active disabled anodes required 0", enableViolations);
        end
        digit_en = 4'hF;

        waitState(127);
        applyStimulus(1'b0, 1'b1, 16'h5555, 4'h0, 4'hF);
        tick();
        load = 1'b0;
        checkAt("bnd_old_d0", 128, 4'hE, 8'h40, 1'b1);
        checkAt("bnd_old_d1", 136, 4'hD, 8'hC0, 1'b0);
        checkAt("bnd_new_d0", 160, 4'hE, 8'h92, 1'b1);
        checkAt("bnd_new_d1", 168, 4'hD, 8'h92, 1'b0);
        checkAt("bnd_new_d2", 176, 4'hB, 8'h92, 1'b0);
        checkAt("bnd_new_d3", 184, 4'h7, 8'h92, 1'b0);

        waitState(205);
        applyStimulus(1'b0, 1'b1, 16'h8888, 4'hF, 4'hF);
        tick();
        load = 1'b0;
        waitState(210);
        reset = 1'b1;
        tick();
        checkOutput("mid_reset", 4'hF, 8'hFF, 1'b0);
        reset = 1'b0;
        watchGhost = 1'b1;
        tick();
        checkOutput("post_reset_first", 4'hE, 8'hC0, 1'b0);
        checkAt("post_d1", 8, 4'hD, 8'hC0, 1'b0);
        checkAt("post_d2", 16, 4'hB, 8'hC0, 1'b0);
        checkAt("post_d3", 24, 4'h7, 8'hC0, 1'b0);
        checkAt("post_f1_d0", 32, 4'hE, 8'hC0, 1'b1);
        checkAt("post_f1_d1", 40, 4'hD, 8'hC0, 1'b0);
        checkAt("post_f1_d2", 48, 4'hB, 8'hC0, 1'b0);
        checkAt("post_f1_d3", 56, 4'h7, 8'hC0, 1'b0);
        watchGhost = 1'b0;
        checks = checks + 1;
        if (ghostHits != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL discarded_value got %0d cycles showing it required 0", ghostHits);
        end

        compareOn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexing controller that drives a 4-digit common-anode seven-segment display from a single shared `seven_segment_decoder` instance. Holds a 16-bit hex value in a double-buffered register, steps one digit at a time through the decoder, and inserts a blanking interval between digits to suppress ghosting. Sits between the datapath that produces display values and the board's segment and anode pins.

## Interface

- `REFRESH_CYCLES`, default 100000: clock cycles per digit slot, including blanking. Must be at least 2.
- `BLANK_CYCLES`, default 1000: cycles at the end of each slot with all anodes off. Must be less than `REFRESH_CYCLES` and at least 0.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `data_in` in 16: value to display; digit *k* shows `data_in[4k+3:4k]`.
- `load` in 1: captures `data_in` and `dp_in` into the shadow register this cycle.
- `dp_in` in 4: decimal point per digit, active-high, captured with `load`.
- `digit_en` in 4: live per-digit enable. When bit *k* is 0, anode *k* is never asserted.
- `segments` out 8: active-low segment pattern; bit 7 is dp. Registered.
- `an` out 4: active-low anode selects; `an[0]` selects digit 0. Registered.
- `frame_done` out 1: one-cycle pulse when a full 4-digit frame completes. Registered.

## Operation

- **Slot counter and digit index.**
  - `cnt` counts 0..`REFRESH_CYCLES`-1 with width `$clog2(REFRESH_CYCLES)`.
  - `digit` is 2 bits. It increments modulo 4 when `cnt == REFRESH_CYCLES-1`, and `cnt` wraps to 0 at the same point.
- **Phase within a slot.**
  - ON phase: `cnt < REFRESH_CYCLES-BLANK_CYCLES`.
  - BLANK phase: the remaining cycles of the slot.
  - FSM states are ON and BLANK, derived from `cnt`. There is no other state.
- **Double buffering.**
  - `load` writes `{dp_in, data_in}` into the shadow register and sets `pending`.
  - At the frame boundary (`cnt == REFRESH_CYCLES-1` and `digit == 3`), if `pending` is set, the shadow register copies into the active register and `pending` clears.
  - A value therefore always appears first on digit 0. A frame never mixes old and new digits.
- **Load at the frame boundary.**
  - If `load` coincides with the boundary, the transfer uses the old shadow contents.
  - The new value is written to the shadow register and `pending` stays 1, so the new value appears one frame later.
- **Per-digit output.**
  - The active nibble for `digit` drives the decoder input.
  - `segments` gets the decoder output `[6:0]`, and `segments[7]` = ~active dp bit.
  - `an` = one-hot-low of `digit`.
- **Blanking.** In BLANK phase, or when `digit_en[digit]` is 0, `an` = 4'b1111 and `segments` = 8'hFF. A disabled digit still consumes its full slot.
- **Arithmetic.** No overflow is possible; `cnt` and `digit` wrap explicitly as described above.

## Timing

- **Reset values.** While `reset` is high at a clock edge:
  - `cnt`=0, `digit`=0, `pending`=0, shadow=0, active=0.
  - `an`=4'b1111, `segments`=8'hFF, `frame_done`=0.
- **Output latency.** Outputs are registered and reflect the `cnt`/`digit`/active state of the previous cycle, a fixed latency of 1.
  - The first non-reset edge produces `an` = 4'b1110 and `segments` = 8'hC0 (digit "0"), provided `digit_en[0]`=1.
- **Frame timing.** One frame is `4*REFRESH_CYCLES` cycles.
  - `frame_done` goes high on the edge after the boundary cycle, together with the first digit-0 output of the new frame, for exactly 1 cycle.
- **Reset mid-operation.** Reset takes effect at the next edge, discards any pending shadow value, and restarts from digit 0 showing 0.
- **`digit_en` changes.** Changes take effect with 1-cycle latency and require no frame alignment.

## Test plan

Parameters for all scenarios: `REFRESH_CYCLES`=8, `BLANK_CYCLES`=2, `digit_en`=4'b1111 unless stated.

- **Reset.** Hold `reset` for 3 cycles → `an`=1111, `segments`=FF, `frame_done`=0. The first edge after release gives `an`=1110, `segments`=C0. `frame_done` first pulses 32 cycles later.
- **Load and scan.** Pulse `load` with `data_in`=16'h1234 and `dp_in`=0 during frame 0. In frame 1:
  - digit 0 shows `segments`=99 with `an`=1110 for 6 cycles, then 2 cycles of 1111/FF;
  - digit 1 shows B0 on 1101;
  - digit 2 shows A4 on 1011;
  - digit 3 shows F9 on 0111.
- **No tearing.** While 16'h1234 is displayed, load 16'hABCD during the digit-1 slot. Digits 2 and 3 of the current frame still show A4 and F9. The next frame shows digit 0 = A1 ("d") through digit 3 = 88 ("A").
- **Enables and decimal points.** Set `digit_en`=4'b0101, load 16'h0000 with `dp_in`=4'b0001. Then:
  - `an[1]` and `an[3]` are never 0;
  - digit 0 shows `segments`=40;
  - digit 2 shows C0.
- **Load at the boundary.** Assert `load` with 16'h5555 exactly on the boundary cycle while `pending`=0. The frame that follows still shows the old value; the next frame shows 92 on every digit.
- **Mid-frame reset.** Assert `reset` during digit 2 with a load pending. The next edge gives 1111/FF. After release, the display shows 0 on all digits, and the discarded pending value never appears.
